spi_txn_arbiter: RTL and testbench

Sequences one shared `protocol_spi` master (CPOL/CPHA set at instantiation) among NREQ byte-level requesters. Arbitration is round-robin. The block drives the master's `ss`, `start` and `data_in`, captures `data_out` on `done`, and returns each result to the owning requester. It also drives one active-low chip select per requester and keeps the grant locked across multi-byte bursts. A watchdog aborts a transfer that never completes.

---
 rtl/spi_txn_arbiter.sv | 139 +++++++++++++
 tb/tb_spi_txn_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_txn_arbiter.sv
// spi_txn_arbiter: round-robin sequencer sharing one SPI master among NREQ byte requesters,
// with per-requester chip selects, burst locking and a completion watchdog.
module spi_txn_arbiter #(
    parameter int NREQ    = 4,
    parameter int GAP     = 2,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [8*NREQ-1:0] req_data,
    input  logic [NREQ-1:0]   req_last,
    output logic [NREQ-1:0]   req_ready,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [7:0]        rsp_data,
    output logic              rsp_err,
    output logic [NREQ-1:0]   cs_n,
    output logic              busy,
    output logic              spi_ss,
    output logic              spi_start,
    output logic [7:0]        spi_data_in,
    input  logic [7:0]        spi_data_out,
    input  logic              spi_done
);
    localparam int GW = NREQ > 1 ? $clog2(NREQ) : 1;
    localparam int TW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
    localparam int CW = GAP > 1 ? $clog2(GAP) : 1;

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_XFER, S_GAP, S_HOLD} state_e;

    state_e          state_q, state_d;
    logic [GW-1:0]   grant_q, grant_d, last_grant_q, last_grant_d;
    logic            last_g_q, last_g_d, lock_q, lock_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [CW-1:0]   gap_q, gap_d;
    logic            ss_q, ss_d, start_q, start_d, rsp_err_q, rsp_err_d, busy_q;
    logic [7:0]      data_in_q, data_in_d, rsp_data_q, rsp_data_d;
    logic [NREQ-1:0] cs_n_q, cs_n_d, req_ready_q, req_ready_d, rsp_valid_q, rsp_valid_d;

    logic [GW-1:0]   arb_g, j, cap_g;
    logic            t_exp, g_exp, capture, xfer_end, keep_lock, hold_exp;

    assign t_exp     = timer_q == TW'(TIMEOUT - 1);
    assign g_exp     = gap_q == CW'(GAP - 1);
    assign capture   = (state_q == S_IDLE && |req_valid) || (state_q == S_HOLD && req_valid[grant_q]);
    assign cap_g     = state_q == S_IDLE ? arb_g : grant_q;
    assign xfer_end  = state_q == S_XFER && (spi_done || t_exp);
    // A done on the expiry edge still wins; only a clean success may keep the burst lock.
    assign keep_lock = spi_done && !last_g_q;
    assign hold_exp  = state_q == S_HOLD && !req_valid[grant_q] && t_exp;

    // Later (closer) offsets overwrite farther ones, leaving the first requester after last_grant.
    always_comb begin
        arb_g = last_grant_q;
        j = '0;
        for (int k = NREQ; k >= 1; k--) begin
            j = GW'((int'(last_grant_q) + k) % NREQ);
            if (req_valid[j]) arb_g = j;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            grant_q      <= '0;
            last_grant_q <= GW'(NREQ - 1);
            last_g_q     <= 1'b0;
            lock_q       <= 1'b0;
            timer_q      <= '0;
            gap_q        <= '0;
            ss_q         <= 1'b1;
            start_q      <= 1'b0;
            data_in_q    <= '0;
            cs_n_q       <= '1;
            req_ready_q  <= '0;
            rsp_valid_q  <= '0;
            rsp_data_q   <= '0;
            rsp_err_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            last_g_q     <= last_g_d;
            lock_q       <= lock_d;
            timer_q      <= timer_d;
            gap_q        <= gap_d;
            ss_q         <= ss_d;
            start_q      <= start_d;
            data_in_q    <= data_in_d;
            cs_n_q       <= cs_n_d;
            req_ready_q  <= req_ready_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
            rsp_err_q    <= rsp_err_d;
            busy_q       <= state_d != S_IDLE;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (capture) state_d = S_SETUP;
            S_SETUP: state_d = S_XFER;
            S_XFER:  if (xfer_end) state_d = S_GAP;
            S_GAP:   if (g_exp) state_d = lock_q ? S_HOLD : S_IDLE;
            S_HOLD:  state_d = capture ? S_SETUP : (hold_exp ? S_IDLE : S_HOLD);
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        grant_d      = capture ? cap_g : grant_q;
        last_grant_d = (state_q == S_IDLE && capture) ? arb_g : last_grant_q;
        last_g_d     = capture ? req_last[cap_g] : last_g_q;
        data_in_d    = capture ? req_data[{cap_g, 3'b000} +: 8] : data_in_q;
        req_ready_d  = capture ? NREQ'(1) << cap_g : '0;
        timer_d      = (state_q == S_XFER || state_q == S_HOLD) ? timer_q + 1'b1 : '0;
        gap_d        = state_q == S_GAP ? gap_q + 1'b1 : '0;
        ss_d         = state_q == S_SETUP ? 1'b0 : (xfer_end ? 1'b1 : ss_q);
        start_d      = state_q == S_SETUP;
        cs_n_d       = state_q == S_SETUP ? ~(NREQ'(1) << grant_q) :
                       ((xfer_end && !keep_lock) || hold_exp) ? '1 : cs_n_q;
        lock_d       = xfer_end ? keep_lock : (hold_exp ? 1'b0 : lock_q);
        rsp_valid_d  = xfer_end ? NREQ'(1) << grant_q : '0;
        rsp_data_d   = xfer_end ? (spi_done ? spi_data_out : 8'h00) : rsp_data_q;
        rsp_err_d    = xfer_end ? !spi_done : rsp_err_q;
    end

    assign req_ready   = req_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_err     = rsp_err_q;
    assign cs_n        = cs_n_q;
    assign busy        = busy_q;
    assign spi_ss      = ss_q;
    assign spi_start   = start_q;
    assign spi_data_in = data_in_q;
endmodule

// File: tb/tb_spi_txn_arbiter.sv
// tb_spi_txn_arbiter: directed and random checks of spi_txn_arbiter against a phase-level model,
// with a behavioural stand-in for the SPI master driving spi_done/spi_data_out.
module tb_spi_txn_arbiter;
    localparam int NREQ = 4;
    localparam int GAP  = 2;
    localparam int TMO  = 64;
    localparam int P_IDLE = 0, P_SETUP = 1, P_XFER = 2, P_GAP = 3, P_HOLD = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [NREQ-1:0]   req_valid = '0, req_last = '0;
    logic [8*NREQ-1:0] req_data = '0;
    logic [NREQ-1:0]   req_ready, rsp_valid, cs_n;
    logic [7:0]        rsp_data, spi_data_in;
    logic              rsp_err, busy, spi_ss, spi_start;
    logic [7:0]        spi_data_out = '0;
    logic              spi_done = 1'b0;

    int n_tests = 0, n_fail = 0;
    int n, s_cnt = -1, lat_fix = -1, dout_fix = -1;

    int       m_ph, m_age, m_owner, m_lg;
    bit       m_locked, m_lastf, m_rerr;
    logic [7:0] m_din, m_rdat;

    spi_txn_arbiter #(.NREQ(NREQ), .GAP(GAP), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .cs_n(cs_n), .busy(busy),
        .spi_ss(spi_ss), .spi_start(spi_start), .spi_data_in(spi_data_in),
        .spi_data_out(spi_data_out), .spi_done(spi_done)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ph = P_IDLE; m_age = 0; m_owner = 0; m_lg = NREQ - 1;
        m_locked = 0; m_lastf = 0; m_rerr = 0; m_din = 0; m_rdat = 0;
    endtask

    task automatic take();
        m_din   = req_data[8*m_owner +: 8];
        m_lastf = req_last[m_owner];
        m_ph    = P_SETUP;
        m_age   = 0;
    endtask

    task automatic enter_gap();
        m_ph = P_GAP; m_age = 0;
    endtask

    // One clock edge of the reference: inputs are the values present at that edge.
    task automatic model_step();
        if (m_ph == P_IDLE) begin
            if (req_valid != 0) begin
                for (int k = 1; k <= NREQ; k++)
                    if (req_valid[(m_lg + k) % NREQ]) begin m_owner = (m_lg + k) % NREQ; break; end
                m_lg = m_owner;
                take();
            end
        end else if (m_ph == P_SETUP) begin
            m_ph = P_XFER; m_age = 0;
        end else if (m_ph == P_XFER) begin
            if (spi_done) begin
                m_rdat = spi_data_out; m_rerr = 0; m_locked = !m_lastf; enter_gap();
            end else if (m_age == TMO - 1) begin
                m_rdat = 0; m_rerr = 1; m_locked = 0; enter_gap();
            end else m_age++;
        end else if (m_ph == P_GAP) begin
            if (m_age == GAP - 1) begin m_ph = m_locked ? P_HOLD : P_IDLE; m_age = 0; end
            else m_age++;
        end else begin
            if (req_valid[m_owner]) take();
            else if (m_age == TMO - 1) begin m_locked = 0; m_ph = P_IDLE; m_age = 0; end
            else m_age++;
        end
    endtask

    function automatic logic [63:0] model_out();
        logic [NREQ-1:0] own = NREQ'(1) << m_owner;
        bit sel = (m_ph == P_XFER) || m_locked;
        return {m_ph != P_XFER, sel ? ~own : {NREQ{1'b1}}, (m_ph == P_XFER && m_age == 0), m_din,
                (m_ph == P_SETUP) ? own : {NREQ{1'b0}},
                (m_ph == P_GAP && m_age == 0) ? own : {NREQ{1'b0}},
                m_rdat, m_rerr, m_ph != P_IDLE};
    endfunction

    function automatic logic [63:0] dut_out();
        return {spi_ss, cs_n, spi_start, spi_data_in, req_ready, rsp_valid, rsp_data, rsp_err, busy};
    endfunction

    function automatic int pick_lat();
        int r = int'($urandom % 16);
        return r == 0 ? TMO - 1 : r == 1 ? TMO : r == 2 ? TMO + 50 : int'($urandom % 12);
    endfunction

    task automatic cycle();
        @(negedge clk);
        if (!rst) model_reset(); else model_step();
        chk("cycle", dut_out(), model_out());
        chk("cs_onehot", 64'($countones(~cs_n) <= 1), 64'd1);
        if (spi_ss) begin
            spi_done = 1'b0; s_cnt = -1;
        end else begin
            if (spi_start) s_cnt = lat_fix >= 0 ? lat_fix : pick_lat();
            else if (s_cnt > 0) s_cnt--;
            if (s_cnt == 0 && !spi_done) begin
                spi_done = 1'b1;
                spi_data_out = dout_fix >= 0 ? 8'(dout_fix) : 8'($urandom);
            end
        end
    endtask

    task automatic drain();
        n = 0;
        while (busy && n < 500) begin cycle(); n++; end
        chk("drain_busy", busy, 0);
    endtask

    initial begin
        int order[$];
        int exp2[6] = '{1, 3, 0, 1, 3, 0};
        logic [7:0] b3[3] = '{8'h11, 8'h22, 8'h33};
        int min_hi, hi, k3, cs_hi, c0_low, rsp2, rcnt;
        bit seen_low, started;

        model_reset();
        repeat (3) cycle();
        chk("rst_ss", spi_ss, 1);
        chk("rst_cs", cs_n, 4'hF);
        chk("rst_busy", busy, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_din", spi_data_in, 0);
        rst = 1'b1;
        cycle();

        // single byte from requester 0
        lat_fix = 16; dout_fix = 8'h3C;
        req_valid = 4'b0001; req_data[7:0] = 8'hA5; req_last = 4'hF;
        cycle();
        chk("t1_ready", req_ready, 4'b0001);
        req_valid = 0;
        cycle();
        chk("t1_ss", spi_ss, 0);
        chk("t1_cs", cs_n, 4'b1110);
        chk("t1_start", spi_start, 1);
        chk("t1_din", spi_data_in, 8'hA5);
        n = 0;
        do begin cycle(); n++; end while (rsp_valid == 0 && n < 200);
        chk("t1_lat", n, 17);
        chk("t1_rsp_valid", rsp_valid, 4'b0001);
        chk("t1_rsp_data", rsp_data, 8'h3C);
        chk("t1_rsp_err", rsp_err, 0);
        chk("t1_cs_rel", cs_n, 4'hF);
        repeat (2) cycle();
        chk("t1_busy", busy, 0);

        // round robin over 1011; last grant was 0
        lat_fix = 5; dout_fix = -1;
        req_valid = 4'b1011; req_data = 32'($urandom);
        min_hi = 1000; hi = 0; seen_low = 0; n = 0;
        while (order.size() < 6 && n < 2000) begin
            cycle(); n++;
            if (req_ready != 0) order.push_back($clog2(req_ready));
            if (spi_ss) hi++;
            else begin
                if (seen_low && hi > 0 && hi < min_hi) min_hi = hi;
                hi = 0; seen_low = 1;
            end
        end
        for (int i = 0; i < 6; i++) chk("t2_order", order.size() > i ? order[i] : -1, exp2[i]);
        chk("t2_gap", 64'(min_hi >= GAP), 1);
        req_valid = 0;
        drain();

        // locked burst from requester 2 while requester 0 waits
        req_valid = 4'b0101; req_data[7:0] = 8'h77; req_data[23:16] = b3[0]; req_last = 4'b0001;
        k3 = 0; cs_hi = 0; c0_low = 0; rsp2 = 0; started = 0; n = 0;
        while (rsp2 < 3 && n < 1000) begin
            cycle(); n++;
            if (req_ready[2] && k3 < 3) begin
                chk("t3_din", spi_data_in, b3[k3]);
                k3++;
                if (k3 < 3) begin req_data[23:16] = b3[k3]; req_last[2] = (k3 == 2); end
                else req_valid[2] = 0;
            end
            if (spi_start) started = 1;
            if (rsp_valid[2]) rsp2++;
            if (started && rsp2 < 3 && cs_n[2]) cs_hi++;
            if (!cs_n[0]) c0_low++;
        end
        chk("t3_rsp", rsp2, 3);
        chk("t3_cs2_low", cs_hi, 0);
        chk("t3_cs0_idle", c0_low, 0);
        n = 0;
        do begin cycle(); n++; end while (req_ready == 0 && n < 100);
        chk("t3_next", req_ready, 4'b0001);
        req_valid = 0; req_last = 4'hF;
        drain();

        // watchdog abort, then normal service
        lat_fix = 1000;
        req_valid = 4'b1000; req_data[31:24] = 8'hC3;
        n = 0;
        do begin cycle(); n++; end while (!spi_start && n < 100);
        req_valid = 0;
        n = 0;
        do begin cycle(); n++; end while (rsp_valid == 0 && n < 200);
        chk("t4_lat", n, TMO);
        chk("t4_rsp_valid", rsp_valid, 4'b1000);
        chk("t4_err", rsp_err, 1);
        chk("t4_data", rsp_data, 0);
        chk("t4_cs", cs_n, 4'hF);
        lat_fix = 4; dout_fix = 8'h5E;
        req_valid = 4'b0010; req_data[15:8] = 8'h42;
        n = 0;
        do begin
            cycle(); n++;
            if (req_ready != 0) req_valid = 0;
        end while (rsp_valid == 0 && n < 200);
        chk("t4b_rsp_valid", rsp_valid, 4'b0010);
        chk("t4b_err", rsp_err, 0);
        chk("t4b_data", rsp_data, 8'h5E);
        drain();

        // requester 1 locks then goes quiet; requester 3 waits behind it
        lat_fix = 3; dout_fix = -1;
        req_valid = 4'b0010; req_data[15:8] = 8'h9A; req_last = 4'b1101;
        n = 0;
        do begin
            cycle(); n++;
            if (req_ready[1]) begin req_valid[1] = 0; req_valid[3] = 1; req_data[31:24] = 8'hD4; end
        end while (!rsp_valid[1] && n < 200);
        chk("t5_rsp", rsp_valid, 4'b0010);
        chk("t5_cs_locked", cs_n, 4'b1101);
        n = 0; rcnt = 0;
        do begin cycle(); n++; if (rsp_valid != 0) rcnt++; end while (!cs_n[1] && n < 200);
        chk("t5_hold_len", n, GAP + TMO);
        chk("t5_no_rsp", rcnt, 0);
        chk("t5_cs_rel", cs_n, 4'hF);
        cycle();
        chk("t5_next", req_ready, 4'b1000);
        req_valid = 0;

        // asynchronous reset in the middle of a transfer
        lat_fix = 30;
        n = 0;
        do begin cycle(); n++; end while (!spi_start && n < 100);
        repeat (5) cycle();
        chk("t6_pre_ss", spi_ss, 0);
        rst = 1'b0;
        #1;
        chk("t6_ss", spi_ss, 1);
        chk("t6_cs", cs_n, 4'hF);
        chk("t6_busy", busy, 0);
        chk("t6_rsp_valid", rsp_valid, 0);
        cycle();
        rst = 1'b1;
        req_valid = 4'hF; req_data = 32'($urandom); req_last = 4'hF;
        cycle();
        chk("t6_first", req_ready, 4'b0001);
        req_valid = 0;
        drain();

        // random traffic
        lat_fix = -1; dout_fix = -1;
        for (int c = 0; c < 4000; c++) begin
            cycle();
            for (int i = 0; i < NREQ; i++) begin
                if (req_ready[i] || (!req_valid[i] && $urandom % 8 == 0)) begin
                    req_valid[i] = (!req_ready[i]) || ($urandom % 2 == 0);
                    req_data[8*i +: 8] = 8'($urandom);
                    req_last[i] = ($urandom % 4) != 0;
                end else if (req_valid[i] && $urandom % 64 == 0) req_valid[i] = 0;
            end
        end
        req_valid = 0;
        n = 0;
        while ((busy || n < 4) && n < 1000) begin cycle(); n++; end
        chk("final_idle", busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
